// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: BITS_PER_CYCLE result bits per clock through a
// ripple full-adder slice, result and flags registered at the end of the run.
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  if ((WIDTH < 2) || (BITS_PER_CYCLE < 1) || (BITS_PER_CYCLE > WIDTH) ||
      ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]          r_a;
  logic [WIDTH-1:0]          r_b;
  logic                      r_carry;
  logic [CNT_W-1:0]          r_cnt;
  logic [WIDTH-1:0]          r_sum;
  logic                      r_c_out;
  logic                      r_ovf;
  logic                      r_zero;

  logic [BITS_PER_CYCLE-1:0] w_slice;
  logic                      w_chain_cout;
  logic                      w_msb_cin;
  logic [WIDTH-1:0]          w_sum_next;
  logic                      w_load;
  logic                      w_last;

  // Operands are accepted whenever no operation is in flight (IDLE or DONE).
  assign w_load = (r_state != RUN) && start;
  assign w_last = (r_state == RUN) && (r_cnt == LAST_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ripple slice; the carry into its top bit is the carry into bit WIDTH-1 on
  // the final step, which is what the overflow flag needs.
  always_comb begin
    logic v_c;
    v_c       = r_carry;
    w_slice   = '0;
    w_msb_cin = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (i == BITS_PER_CYCLE - 1) w_msb_cin = v_c;
      w_slice[i] = r_a[i] ^ r_b[i] ^ v_c;
      v_c        = (r_a[i] & r_b[i]) | (v_c & (r_a[i] ^ r_b[i]));
    end
    w_chain_cout = v_c;
  end

  if (BITS_PER_CYCLE == WIDTH) begin : g_one_step
    assign w_sum_next = w_slice;
  end else begin : g_multi_step
    assign w_sum_next = {w_slice, r_sum[WIDTH-1:BITS_PER_CYCLE]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : c_in;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> BITS_PER_CYCLE;
      r_b     <= r_b >> BITS_PER_CYCLE;
      r_carry <= w_chain_cout;
      r_sum   <= w_sum_next;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_c_out <= w_chain_cout;
        r_ovf   <= w_msb_cin ^ w_chain_cout;
        r_zero  <= (w_sum_next == '0);
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: four configurations share one stimulus bus and are
// checked against hand-computed vectors and a plain integer arithmetic model.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        c_in;
  logic [31:0] a;
  logic [31:0] b;

  logic        busy0, done0, cout0, ovf0, zero0;
  logic        busy1, done1, cout1, ovf1, zero1;
  logic        busy2, done2, cout2, ovf2, zero2;
  logic        busy3, done3, cout3, ovf3, zero3;
  logic [7:0]  sum0, sum1;
  logic [15:0] sum2;
  logic [31:0] sum3;
  logic [1:0]  st0, st1, st2, st3;

  logic [3:0]  done_v, busy_v, cout_v, ovf_v, zero_v;
  logic [7:0]  dbg_v;
  logic [31:0] sum_v [4];

  localparam int CFG_W [4] = '{8, 8, 16, 32};
  localparam int CFG_N [4] = '{8, 2, 8, 1};

  int checks   = 0;
  int failures = 0;

  int          lat    [4];
  logic [31:0] c_sum  [4];
  logic        c_cout [4];
  logic        c_ovf  [4];
  logic        c_zero [4];

  typedef struct {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t tbl [11];

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]),
    .c_in(c_in), .busy(busy0), .done(done0), .sum(sum0), .c_out(cout0),
    .ovf(ovf0), .zero(zero0), .dbg_state(st0));

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]),
    .c_in(c_in), .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1),
    .ovf(ovf1), .zero(zero1), .dbg_state(st1));

  serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]),
    .c_in(c_in), .busy(busy2), .done(done2), .sum(sum2), .c_out(cout2),
    .ovf(ovf2), .zero(zero2), .dbg_state(st2));

  serial_addsub #(.WIDTH(32), .BITS_PER_CYCLE(32)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .c_in(c_in), .busy(busy3), .done(done3), .sum(sum3), .c_out(cout3),
    .ovf(ovf3), .zero(zero3), .dbg_state(st3));

  assign done_v   = {done3, done2, done1, done0};
  assign busy_v   = {busy3, busy2, busy1, busy0};
  assign cout_v   = {cout3, cout2, cout1, cout0};
  assign ovf_v    = {ovf3, ovf2, ovf1, ovf0};
  assign zero_v   = {zero3, zero2, zero1, zero0};
  assign dbg_v    = {st3, st2, st1, st0};
  assign sum_v[0] = {24'd0, sum0};
  assign sum_v[1] = {24'd0, sum1};
  assign sum_v[2] = {16'd0, sum2};
  assign sum_v[3] = sum3;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model(input int w, input logic s, input logic ci,
                                input logic [31:0] fa, input logic [31:0] fb,
                                output logic [31:0] rs, output logic rc,
                                output logic ro, output logic rz);
    logic [32:0] mask;
    logic [32:0] full;
    logic [31:0] aa;
    logic [31:0] bb;
    mask = (33'd1 << w) - 33'd1;
    aa   = fa & mask[31:0];
    bb   = (s ? ~fb : fb) & mask[31:0];
    full = {1'b0, aa} + {1'b0, bb} + {32'd0, (s | ci)};
    rs   = full[31:0] & mask[31:0];
    rc   = full[w];
    ro   = (aa[w-1] == bb[w-1]) && (rs[w-1] != aa[w-1]);
    rz   = (rs == 32'd0);
  endfunction

  // Pulse start for one edge, scramble the inputs, then record each
  // instance's first done (edges counted from the sampling edge).
  task automatic run_op(input logic op_sub, input logic op_cin,
                        input logic [31:0] op_a, input logic [31:0] op_b);
    int         cnt;
    logic [3:0] seen;
    sub   = op_sub;
    c_in  = op_cin;
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sub   = 1'($urandom_range(0, 1));
    c_in  = 1'($urandom_range(0, 1));
    cnt   = 1;
    seen  = 4'h0;
    check("busy_after_start", 32'(busy_v), 32'hF);
    check("dbg_run_after_start", 32'(dbg_v), 32'h55);
    while ((seen != 4'hF) && (cnt <= 40)) begin
      for (int i = 0; i < 4; i++) begin
        if (done_v[i] && !seen[i]) begin
          seen[i]   = 1'b1;
          lat[i]    = cnt;
          c_sum[i]  = sum_v[i];
          c_cout[i] = cout_v[i];
          c_ovf[i]  = ovf_v[i];
          c_zero[i] = zero_v[i];
        end
      end
      if (seen != 4'hF) begin
        @(posedge clk);
        #1;
        cnt++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!seen[i]) lat[i] = -1;
    end
  endtask

  task automatic check_results(input string tag, input vec_t v,
                               input logic [31:0] fa, input logic [31:0] fb);
    logic [31:0] rs;
    logic        rc, ro, rz;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_d%0d_lat", tag, i), 32'(lat[i]), 32'(CFG_N[i] + 1));
      check($sformatf("%s_d%0d_sum", tag, i), c_sum[i], {24'd0, v.sum});
      check($sformatf("%s_d%0d_cout", tag, i), 32'(c_cout[i]), 32'(v.cout));
      check($sformatf("%s_d%0d_ovf", tag, i), 32'(c_ovf[i]), 32'(v.ovf));
      check($sformatf("%s_d%0d_zero", tag, i), 32'(c_zero[i]), 32'(v.zero));
    end
    for (int i = 2; i < 4; i++) begin
      model(CFG_W[i], v.sub, v.cin, fa, fb, rs, rc, ro, rz);
      check($sformatf("%s_d%0d_lat", tag, i), 32'(lat[i]), 32'(CFG_N[i] + 1));
      check($sformatf("%s_d%0d_sum", tag, i), c_sum[i], rs);
      check($sformatf("%s_d%0d_cout", tag, i), 32'(c_cout[i]), 32'(rc));
      check($sformatf("%s_d%0d_ovf", tag, i), 32'(c_ovf[i]), 32'(ro));
      check($sformatf("%s_d%0d_zero", tag, i), 32'(c_zero[i]), 32'(rz));
    end
  endtask

  task automatic wait_done0(inout int cnt);
    while (!done0 && (cnt < 40)) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t        v;
    logic [31:0] r1, r2, fa, fb, rs;
    logic        rc, ro, rz;
    int          cnt;

    //            sub  cin  a      b      sum    cout ovf  zero
    tbl[0]  = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    c_in  = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy_v), 32'h0);
    check("reset_done", 32'(done_v), 32'h0);
    check("reset_dbg", 32'(dbg_v), 32'h0);
    check("reset_sum0", sum_v[0], 32'h0);
    check("reset_sum3", sum_v[3], 32'h0);
    check("reset_flags", {20'd0, cout_v, ovf_v, zero_v}, 32'h0);
    #2 rst_n = 1'b1;

    // Table vectors; first start lands on the first edge after reset release.
    for (int i = 0; i < 11; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      fa = {r1[31:8], tbl[i].a};
      fb = {r2[31:8], tbl[i].b};
      run_op(tbl[i].sub, tbl[i].cin, fa, fb);
      check_results($sformatf("vec%0d", i), tbl[i], fa, fb);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("vec%0d_hold_sum0", i), sum_v[0], {24'd0, tbl[i].sum});
    end

    for (int i = 0; i < 30; i++) begin
      fa    = $urandom;
      fb    = $urandom;
      v.sub = 1'($urandom_range(0, 1));
      v.cin = 1'($urandom_range(0, 1));
      v.a   = fa[7:0];
      v.b   = fb[7:0];
      model(8, v.sub, v.cin, fa, fb, rs, rc, ro, rz);
      v.sum  = rs[7:0];
      v.cout = rc;
      v.ovf  = ro;
      v.zero = rz;
      run_op(v.sub, v.cin, fa, fb);
      check_results($sformatf("rnd%0d", i), v, fa, fb);
    end
    repeat (3) @(posedge clk);
    #1;

    // start pulsed mid-RUN with other operands: d0 keeps its operation, d1
    // (already finished) takes the new one.
    sub   = 1'b0;
    c_in  = 1'b0;
    a     = 32'h12;
    b     = 32'h34;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt   = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    a     = 32'hAA;
    b     = 32'h11;
    sub   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    cnt++;
    start = 1'b0;
    check("midrun_busy0", 32'(busy0), 32'h1);
    wait_done0(cnt);
    check("midrun_lat0", 32'(cnt), 32'd9);
    check("midrun_sum0", sum_v[0], 32'h46);
    check("midrun_flags0", {29'd0, cout0, ovf0, zero0}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("midrun_sum1", sum_v[1], 32'h99);
    check("midrun_cout1", 32'(cout1), 32'h1);
    repeat (10) @(posedge clk);
    #1;

    // start held high through DONE: back-to-back operation.
    sub   = 1'b0;
    c_in  = 1'b0;
    a     = 32'h10;
    b     = 32'h20;
    start = 1'b1;
    @(posedge clk);
    #1;
    cnt = 1;
    wait_done0(cnt);
    check("b2b_lat0_first", 32'(cnt), 32'd9);
    check("b2b_sum0_first", sum_v[0], 32'h30);
    a   = 32'h01;
    b   = 32'h02;
    sub = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy0", 32'(busy0), 32'h1);
    check("b2b_done0", 32'(done0), 32'h0);
    cnt = 1;
    wait_done0(cnt);
    check("b2b_lat0_second", 32'(cnt), 32'd9);
    check("b2b_sum0_second", sum_v[0], 32'hFF);
    check("b2b_flags0_second", {29'd0, cout0, ovf0, zero0}, 32'h0);
    repeat (12) @(posedge clk);
    #1;

    // Reset asserted during RUN step 3 with non-zero held results.
    run_op(tbl[5].sub, tbl[5].cin, 32'h80, 32'h01);
    check_results("pre_reset", tbl[5], 32'h80, 32'h01);
    sub   = 1'b0;
    c_in  = 1'b0;
    a     = 32'h12;
    b     = 32'h34;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy_v), 32'h0);
    check("rst_mid_done", 32'(done_v), 32'h0);
    check("rst_mid_sum0", sum_v[0], 32'h0);
    check("rst_mid_sum3", sum_v[3], 32'h0);
    check("rst_mid_flags", {20'd0, cout_v, ovf_v, zero_v}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_op(tbl[0].sub, tbl[0].cin, 32'h0000_007F, 32'h0000_0001);
    check_results("post_reset", tbl[0], 32'h0000_007F, 32'h0000_0001);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
